serial_word_rx: RTL and testbench

Bit-serial deserializer that collects WIDTH bits, LSB first, into a parallel word and presents it on a valid/ready output. It sits directly upstream of the sign extender: `out_data` feeds the extender's `in` with FROM_WIDTH = WIDTH. A single output buffer plus the shift register give two words of storage. Back-pressure propagates to the serial side through `ser_ready`.

---
 rtl/serial_rx_pkg.sv | 16 +
 rtl/word_buf.sv | 50 +++++
 rtl/serial_word_rx.sv | 115 +++++++++++
 tb/tb_serial_word_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and helpers for the serial word receiver
// Contents:
//   state_t : receiver FSM states (ST_SHIFT collects bits, ST_HOLD stalls the serial side)
//   cnt_w   : width of the bit counter for a given word width
package serial_rx_pkg;

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/word_buf.sv
// rtl/word_buf.sv - single-entry valid/ready holding register
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   load, load_data    : write a word into the entry (caller only loads when empty or being drained)
//   out_data, out_valid: registered entry contents and occupancy
//   out_ready          : downstream accepts the entry this cycle
module word_buf
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // A load in the same cycle as an accept wins, so the entry refills without a bubble.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - LSB-first bit-serial to parallel word deserializer
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   ser_data, ser_valid  : serial bit input
//   ser_ready            : a bit is accepted this cycle (low only while a finished word waits)
//   ser_sync             : restart framing, dropping any partial word
//   out_data, out_valid  : assembled word, registered
//   out_ready            : downstream accepts out_data
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_data,
    input  logic             ser_valid,
    output logic             ser_ready,
    input  logic             ser_sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    if (WIDTH < 2) begin : g_width_check
        $error("serial_word_rx: WIDTH must be at least 2");
    end

    localparam int                 CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;

    logic             bit_accept;
    logic             word_done;
    logic             buf_free;
    logic [WIDTH-1:0] shifted;
    logic             buf_load;
    logic [WIDTH-1:0] buf_load_data;

    assign shifted    = {ser_data, sr_q[WIDTH-1:1]};
    assign bit_accept = ser_valid && ser_ready;
    // Sync takes priority: a bit arriving with sync starts a new frame, never completes one.
    assign word_done  = bit_accept && !ser_sync && (cnt_q == CNT_LAST);
    assign buf_free   = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        unique case (state_q)
            ST_SHIFT: begin
                if (ser_sync) begin
                    cnt_d = ser_valid ? CNT_W'(1) : '0;
                    if (ser_valid) begin
                        sr_d = shifted;
                    end
                end else if (bit_accept) begin
                    // On a stalled completion the finished word parks in sr until the buffer drains.
                    sr_d  = shifted;
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                    if (word_done && !buf_free) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_SHIFT;
        endcase
    end

    always_comb begin
        ser_ready     = (state_q == ST_SHIFT);
        buf_load      = 1'b0;
        buf_load_data = shifted;
        if (state_q == ST_HOLD) begin
            buf_load      = out_valid && out_ready;
            buf_load_data = sr_q;
        end else if (word_done && buf_free) begin
            buf_load = 1'b1;
        end
    end

    word_buf #(
        .WIDTH(WIDTH)
    ) u_word_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_data (buf_load_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - self-checking bench for serial_word_rx
module tb_serial_word_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ser_data = 1'b0;
    logic        ser_valid = 1'b0;
    logic        ser_sync = 1'b0;
    logic        out_ready = 1'b0;
    logic        ser_ready;
    logic        out_valid;
    logic [15:0] out_data;

    int tests = 0;
    int fails = 0;

    serial_word_rx #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_sync  (ser_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            ser_valid = 1'b1;
            ser_data  = w[i];
            tick();
        end
        ser_valid = 1'b0;
    endtask

    logic [15:0] words2 [2];
    logic [15:0] pre    [5];
    logic [15:0] w;
    logic [15:0] cap;
    logic [31:0] ext;
    int          pulses, drops;

    logic [15:0] exp_q [$];
    logic [15:0] cur_w, hold_val;
    logic        hold_pending;
    int          bit_i, words_sent, words_got, cycles;

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_ser_ready", 32'(ser_ready), 32'd1);
        @(negedge clk) rst = 1'b0;

        // Single word, latency and one-cycle valid pulse
        out_ready = 1'b1;
        w = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            ser_valid = 1'b1;
            ser_data  = w[i];
            tick();
            if (i == 14) chk("w1_early_valid", 32'(out_valid), 32'd0);
        end
        ser_valid = 1'b0;
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data",  32'(out_data),  32'h8001);
        ext = {{16{out_data[15]}}, out_data};
        chk("w1_sext", ext, 32'hFFFF8001);
        tick();
        chk("w1_pulse_end", 32'(out_valid), 32'd0);

        // Back-to-back words, no bubble, no ready drop
        words2[0] = 16'h1234;
        words2[1] = 16'hFFFF;
        pulses = 0;
        drops  = 0;
        for (int i = 0; i < 32; i++) begin
            if (!ser_ready) drops++;
            w = words2[i / 16];
            ser_valid = 1'b1;
            ser_data  = w[i % 16];
            tick();
            if (out_valid) pulses++;
            if (i == 15) chk("b2b_word0", 32'(out_data), 32'h1234);
            if (i == 31) chk("b2b_word1", 32'(out_data), 32'hFFFF);
            if (i == 15 || i == 31) chk("b2b_valid", 32'(out_valid), 32'd1);
        end
        ser_valid = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_drops",  32'(drops),  32'd0);
        tick();

        // Back-pressure into HOLD and release
        out_ready = 1'b0;
        send_word(16'h00AA);
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_data",  32'(out_data),  32'h00AA);
        chk("bp_ready_mid",   32'(ser_ready), 32'd1);
        send_word(16'h5500);
        chk("bp_hold_ready", 32'(ser_ready), 32'd0);
        chk("bp_hold_data",  32'(out_data),  32'h00AA);
        out_ready = 1'b1;
        #1;
        chk("bp_out0", 32'(out_data), 32'h00AA);
        tick();
        chk("bp_out1_valid", 32'(out_valid), 32'd1);
        chk("bp_out1_data",  32'(out_data),  32'h5500);
        chk("bp_ready_back", 32'(ser_ready), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Sync drops partial word
        pulses = 0;
        pre[0] = 16'd1; pre[1] = 16'd0; pre[2] = 16'd1; pre[3] = 16'd1; pre[4] = 16'd0;
        for (int i = 0; i < 5; i++) begin
            ser_valid = 1'b1;
            ser_data  = pre[i][0];
            tick();
            if (out_valid) pulses++;
        end
        w = 16'hC3C3;
        for (int i = 0; i < 16; i++) begin
            ser_sync  = (i == 0);
            ser_valid = 1'b1;
            ser_data  = w[i];
            tick();
            if (out_valid) begin
                pulses++;
                cap = out_data;
            end
        end
        ser_sync  = 1'b0;
        ser_valid = 1'b0;
        chk("sync_pulses", 32'(pulses), 32'd1);
        chk("sync_valid",  32'(out_valid), 32'd1);
        chk("sync_data",   32'(cap), 32'hC3C3);
        tick();

        // Reset while holding
        out_ready = 1'b0;
        send_word(16'hA5A5);
        send_word(16'h3C3C);
        chk("rh_in_hold",  32'(ser_ready), 32'd0);
        chk("rh_valid_hi", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rh_out_valid", 32'(out_valid), 32'd0);
        chk("rh_out_data",  32'(out_data),  32'd0);
        chk("rh_ser_ready", 32'(ser_ready), 32'd1);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        send_word(16'h7FFF);
        chk("rh_next_valid", 32'(out_valid), 32'd1);
        chk("rh_next_data",  32'(out_data),  32'h7FFF);
        tick();

        // Random traffic against a word-level scoreboard
        cur_w = 16'($urandom);
        bit_i = 0;
        words_sent = 0;
        words_got  = 0;
        cycles = 0;
        hold_pending = 1'b0;
        while (words_got < 1000 && cycles < 60000) begin
            ser_valid = (words_sent < 1000) && ($urandom_range(3) != 0);
            ser_data  = cur_w[bit_i];
            out_ready = ($urandom_range(4) > 1);
            ser_sync  = 1'b0;
            #1;
            if (hold_pending) begin
                chk("rand_hold_valid", 32'(out_valid), 32'd1);
                chk("rand_hold_data",  32'(out_data),  32'(hold_val));
            end
            hold_pending = out_valid && !out_ready;
            hold_val     = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rand_spurious", 32'd1, 32'd0);
                else chk("rand_word", 32'(out_data), 32'(exp_q.pop_front()));
                words_got++;
            end
            if (ser_valid && ser_ready) begin
                bit_i++;
                if (bit_i == 16) begin
                    exp_q.push_back(cur_w);
                    words_sent++;
                    cur_w = 16'($urandom);
                    bit_i = 0;
                end
            end
            tick();
            cycles++;
        end
        if (words_got < 1000) chk("rand_timeout", 32'(words_got), 32'd1000);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
